scan_index_gen: RTL and testbench

//  Produces the 3-bit one-of-eight select index that drives the 3-to-8 decoder stage
//  (idx[2]->a, idx[1]->b, idx[0]->c), so it sits directly upstream of the decoder.

---
 rtl/scan_index_gen_pkg.sv | 24 ++
 rtl/scan_index_gen_if.sv | 16 +
 rtl/scan_index_gen_tick_divider.sv | 26 ++
 rtl/scan_index_gen.sv | 84 ++++++++
 tb/tb_scan_index_gen.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/scan_index_gen_pkg.sv
// Shared types and defaults for the scan index generator.
// Holds the FSM state encodings and the index-step helpers.
package scan_pkg;

    localparam int DEF_CLK_DIV = 50000;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        ACK  = 2'd3
    } state_e;

    // Modulo-8 step: dir=0 counts up, dir=1 counts down.
    function automatic logic [2:0] idx_adv(input logic [2:0] idx, input logic dir);
        return dir ? idx - 3'd1 : idx + 3'd1;
    endfunction

    function automatic logic idx_wraps(input logic [2:0] idx, input logic dir);
        return dir ? (idx == 3'd0) : (idx == 3'd7);
    endfunction

endpackage

// File: rtl/scan_index_gen_if.sv
// Control/status bundle between a scan controller and the index generator.
interface scan_index_gen_if;
    logic       start;
    logic       stop;
    logic       dir;
    logic       step_req;
    logic       step_ack;
    logic [2:0] idx;
    logic       wrap;
    logic       busy;

    modport master (output start, stop, dir, step_req,
                    input  step_ack, idx, wrap, busy);
    modport slave  (input  start, stop, dir, step_req,
                    output step_ack, idx, wrap, busy);
endinterface

// File: rtl/scan_index_gen_tick_divider.sv
// Prescaler: one-cycle tick every CLK_DIV enabled cycles; held at zero while disabled.
module tick_divider #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (en && !tick) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/scan_index_gen.sv
// One-of-eight select index generator for the 3-to-8 decoder stage:
// prescaled free-run up/down scanning plus 4-phase single-step.
module scan_index_gen
    import scan_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_index_gen_if.slave   bus
);
    state_e     state_q;
    logic [2:0] idx_q, idx_d;
    logic       wrap_q, wrap_d;
    logic       ack_q;
    logic       busy_q;
    logic       tick;

    // A stop in RUN clears the prescaler on the same edge, so IDLE always sees zero.
    tick_divider #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   ((state_q == RUN) && !bus.stop),
        .tick (tick)
    );

    always_comb begin
        idx_d  = idx_adv(idx_q, bus.dir);
        wrap_d = idx_wraps(idx_q, bus.dir);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            wrap_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else if (bus.step_req && !bus.stop) begin
                        state_q <= STEP;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        idx_q  <= idx_d;
                        wrap_q <= wrap_d;
                    end
                end
                STEP: begin
                    idx_q   <= idx_d;
                    wrap_q  <= wrap_d;
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    // stop is deliberately ignored so the requester always sees ack fall.
                    if (!bus.step_req) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.idx      = idx_q;
    assign bus.wrap     = wrap_q;
    assign bus.step_ack = ack_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_scan_index_gen.sv
// Directed table-driven bench for scan_index_gen with a prescale of 4.
module tb_scan_index_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    scan_index_gen_if bus ();

    scan_index_gen #(.CLK_DIV(4), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       dir;
        logic       step_req;
        int         n;
        logic [2:0] idx;
        logic       wrap;
        logic       ack;
        logic       busy;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic st, input logic sp, input logic d, input logic sr,
                       input int n, input logic [2:0] i, input logic w,
                       input logic a, input logic b);
        vec_t v;
        v.start = st; v.stop = sp; v.dir = d; v.step_req = sr; v.n = n;
        v.idx = i; v.wrap = w; v.ack = a; v.busy = b;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0d want %0d", nm, k, act, exp);
        end
    endtask

    task automatic chk_all(input int k, input logic [2:0] i, input logic w,
                           input logic a, input logic b);
        chk("idx", k, int'(bus.idx), int'(i));
        chk("wrap", k, int'(bus.wrap), int'(w));
        chk("step_ack", k, int'(bus.step_ack), int'(a));
        chk("busy", k, int'(bus.busy), int'(b));
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.dir = 0; bus.step_req = 0;

        //     st sp d  sr  n  idx w  a  b
        // idle hold
        add(0, 0, 0, 0, 20, 0, 0, 0, 0);
        // free-run up; start released once in RUN
        add(1, 0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 4, 1, 0, 0, 1);
        for (int i = 2; i <= 7; i++) add(0, 0, 0, 0, 4, 3'(i), 0, 0, 1);
        add(0, 0, 0, 0, 4, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1);
        // dir flip mid-period: prescaler not reset, next tick 3 edges on
        add(0, 0, 1, 0, 3, 7, 1, 0, 1);
        add(0, 0, 1, 0, 1, 7, 0, 0, 1);
        add(0, 0, 1, 0, 3, 6, 0, 0, 1);
        add(0, 0, 1, 0, 3, 6, 0, 0, 1);
        // stop on the tick cycle discards the tick
        add(0, 1, 1, 0, 1, 6, 0, 0, 0);
        add(0, 0, 1, 0, 2, 6, 0, 0, 0);
        // step down 6->5->4->3
        add(0, 0, 1, 1, 1, 6, 0, 0, 1);
        add(0, 0, 1, 1, 1, 5, 0, 1, 1);
        add(0, 0, 1, 0, 1, 5, 0, 0, 0);
        add(0, 0, 1, 1, 2, 4, 0, 1, 1);
        add(0, 0, 1, 0, 1, 4, 0, 0, 0);
        add(0, 0, 1, 1, 2, 3, 0, 1, 1);
        add(0, 0, 1, 0, 1, 3, 0, 0, 0);
        // single step up at 3, held request gives one advance
        add(0, 0, 0, 1, 2, 4, 0, 1, 1);
        add(0, 0, 0, 1, 10, 4, 0, 1, 1);
        add(0, 0, 0, 0, 1, 4, 0, 0, 0);
        // start beats step_req; pending step served after return to IDLE
        add(1, 0, 0, 1, 1, 4, 0, 0, 1);
        add(0, 0, 0, 1, 1, 4, 0, 0, 1);
        add(0, 1, 0, 1, 1, 4, 0, 0, 0);
        add(0, 0, 0, 1, 1, 4, 0, 0, 1);
        add(0, 0, 0, 1, 1, 5, 0, 1, 1);
        // stop ignored in ACK
        add(0, 1, 0, 1, 3, 5, 0, 1, 1);
        add(0, 1, 0, 0, 1, 5, 0, 0, 0);
        add(0, 0, 0, 0, 1, 5, 0, 0, 0);

        // reset values while held in reset
        edges(2);
        chk_all(-1, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (tv[k]) begin
            bus.start = tv[k].start; bus.stop = tv[k].stop;
            bus.dir = tv[k].dir; bus.step_req = tv[k].step_req;
            edges(tv[k].n);
            chk_all(k, tv[k].idx, tv[k].wrap, tv[k].ack, tv[k].busy);
        end

        // reset mid-RUN: 5 -> 6 after entry + 4 edges
        bus.start = 1;
        edges(6);
        bus.start = 0;
        chk_all(100, 6, 0, 0, 1);
        #3 rst_n = 1'b0;
        #1 chk_all(101, 0, 0, 0, 0);
        #1 rst_n = 1'b1;

        // reset mid-ACK drops step_ack asynchronously
        bus.step_req = 1;
        edges(2);
        chk_all(102, 1, 0, 1, 1);
        #3 rst_n = 1'b0;
        #1 chk_all(103, 0, 0, 0, 0);
        bus.step_req = 0;
        #1 rst_n = 1'b1;
        edges(20);
        chk_all(104, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
